// File: rtl/e203_soc_pad_ctrl.sv
// Pad/AON shell for reduced E203 builds: drives every chip pad from a small
// register file, synchronizes and latches straps, runs a 32-bit low-frequency
// timer with a compare interrupt and generates the core's system reset.
// Ports: hfextclk/rst (sync, active high) clock and reset; lfextclk timer tick
// source; io_pads_* pad ring; reg_* simple peripheral register bus;
// sys_rst core reset; tmr_irq timer interrupt.
module e203_soc_pad_ctrl (
  input  logic        hfextclk,
  input  logic        rst,
  input  logic        lfextclk,
  output logic        hfxoscen,
  output logic        lfxoscen,
  input  logic        io_pads_jtag_TCK_i_ival,
  input  logic        io_pads_jtag_TMS_i_ival,
  input  logic        io_pads_jtag_TDI_i_ival,
  output logic        io_pads_jtag_TDO_o_oval,
  output logic        io_pads_jtag_TDO_o_oe,
  input  logic [31:0] io_pads_gpioA_i_ival,
  output logic [31:0] io_pads_gpioA_o_oval,
  output logic [31:0] io_pads_gpioA_o_oe,
  input  logic [31:0] io_pads_gpioB_i_ival,
  output logic [31:0] io_pads_gpioB_o_oval,
  output logic [31:0] io_pads_gpioB_o_oe,
  output logic        io_pads_qspi0_sck_o_oval,
  output logic        io_pads_qspi0_cs_0_o_oval,
  input  logic        io_pads_qspi0_dq_0_i_ival,
  output logic        io_pads_qspi0_dq_0_o_oval,
  output logic        io_pads_qspi0_dq_0_o_oe,
  input  logic        io_pads_qspi0_dq_1_i_ival,
  output logic        io_pads_qspi0_dq_1_o_oval,
  output logic        io_pads_qspi0_dq_1_o_oe,
  input  logic        io_pads_qspi0_dq_2_i_ival,
  output logic        io_pads_qspi0_dq_2_o_oval,
  output logic        io_pads_qspi0_dq_2_o_oe,
  input  logic        io_pads_qspi0_dq_3_i_ival,
  output logic        io_pads_qspi0_dq_3_o_oval,
  output logic        io_pads_qspi0_dq_3_o_oe,
  input  logic        io_pads_aon_erst_n_i_ival,
  input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
  output logic        io_pads_aon_pmu_vddpaden_o_oval,
  output logic        io_pads_aon_pmu_padrst_o_oval,
  input  logic        io_pads_bootrom_n_i_ival,
  input  logic        io_pads_dbgmode0_n_i_ival,
  input  logic        io_pads_dbgmode1_n_i_ival,
  input  logic        io_pads_dbgmode2_n_i_ival,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [5:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        sys_rst,
  output logic        tmr_irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned SW = 5;

  localparam logic [AW-1:0] A_GPIOA_OUT = AW'(6'h00);
  localparam logic [AW-1:0] A_GPIOA_OE  = AW'(6'h04);
  localparam logic [AW-1:0] A_GPIOA_IN  = AW'(6'h08);
  localparam logic [AW-1:0] A_GPIOB_OUT = AW'(6'h0C);
  localparam logic [AW-1:0] A_GPIOB_OE  = AW'(6'h10);
  localparam logic [AW-1:0] A_GPIOB_IN  = AW'(6'h14);
  localparam logic [AW-1:0] A_STATUS    = AW'(6'h18);
  localparam logic [AW-1:0] A_RESET_VEC = AW'(6'h1C);
  localparam logic [AW-1:0] A_MTIME     = AW'(6'h20);
  localparam logic [AW-1:0] A_MTIMECMP  = AW'(6'h24);
  localparam logic [AW-1:0] A_IRQ       = AW'(6'h28);

  localparam logic [DW-1:0] VEC_ROM   = DW'(32'h0000_1000);
  localparam logic [DW-1:0] VEC_FLASH = DW'(32'h2000_0000);

  // Fixed pad drive: oscillators on, JTAG TDO and QSPI parked idle
  assign hfxoscen                  = 1'b1;
  assign lfxoscen                  = 1'b1;
  assign io_pads_jtag_TDO_o_oval   = 1'b0;
  assign io_pads_jtag_TDO_o_oe     = 1'b0;
  assign io_pads_qspi0_sck_o_oval  = 1'b0;
  assign io_pads_qspi0_cs_0_o_oval = 1'b1;
  assign io_pads_qspi0_dq_0_o_oval = 1'b0;
  assign io_pads_qspi0_dq_0_o_oe   = 1'b0;
  assign io_pads_qspi0_dq_1_o_oval = 1'b0;
  assign io_pads_qspi0_dq_1_o_oe   = 1'b0;
  assign io_pads_qspi0_dq_2_o_oval = 1'b0;
  assign io_pads_qspi0_dq_2_o_oe   = 1'b0;
  assign io_pads_qspi0_dq_3_o_oval = 1'b0;
  assign io_pads_qspi0_dq_3_o_oe   = 1'b0;

  // Debug and QSPI inputs are not consumed by this shell
  logic unused_pads;
  assign unused_pads = ^{io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival,
                         io_pads_jtag_TDI_i_ival, io_pads_qspi0_dq_0_i_ival,
                         io_pads_qspi0_dq_1_i_ival, io_pads_qspi0_dq_2_i_ival,
                         io_pads_qspi0_dq_3_i_ival};

  // External reset synchronizer; resets low so the chip stays in reset until erst_n is seen high
  logic erst_s1, erst_s2;
  always_ff @(posedge hfextclk) begin
    if (rst) begin
      erst_s1 <= 1'b0;
      erst_s2 <= 1'b0;
    end else begin
      erst_s1 <= io_pads_aon_erst_n_i_ival;
      erst_s2 <= erst_s1;
    end
  end

  logic irst;
  assign irst = rst | ~erst_s2;

  // System reset and PMU pad controls
  always_ff @(posedge hfextclk) begin
    sys_rst                         <= irst;
    io_pads_aon_pmu_padrst_o_oval   <= irst;
    io_pads_aon_pmu_vddpaden_o_oval <= ~irst;
  end

  // Data synchronizers (no reset: they only carry sampled pad levels)
  logic [DW-1:0] gpioa_s1, gpioa_s2, gpiob_s1, gpiob_s2;
  logic [SW-1:0] strap_s1, strap_s2;
  logic [2:0]    lf_sync;
  always_ff @(posedge hfextclk) begin
    gpioa_s1 <= io_pads_gpioA_i_ival;
    gpioa_s2 <= gpioa_s1;
    gpiob_s1 <= io_pads_gpioB_i_ival;
    gpiob_s2 <= gpiob_s1;
    strap_s1 <= {io_pads_aon_pmu_dwakeup_n_i_ival, io_pads_dbgmode2_n_i_ival,
                 io_pads_dbgmode1_n_i_ival, io_pads_dbgmode0_n_i_ival,
                 io_pads_bootrom_n_i_ival};
    strap_s2 <= strap_s1;
    lf_sync  <= {lf_sync[1:0], lfextclk};
  end

  logic lf_tick;
  assign lf_tick = lf_sync[1] & ~lf_sync[2];

  // Straps track the pins throughout reset, so the last reset cycle's value is what sticks
  logic [SW-1:0] strap_q;
  always_ff @(posedge hfextclk) begin
    if (irst) strap_q <= strap_s2;
  end

  // Register file, timer and interrupt
  logic [DW-1:0] mtime, mtimecmp;
  always_ff @(posedge hfextclk) begin
    if (irst) begin
      io_pads_gpioA_o_oval <= '0;
      io_pads_gpioA_o_oe   <= '0;
      io_pads_gpioB_o_oval <= '0;
      io_pads_gpioB_o_oe   <= '0;
      mtime                <= '0;
      mtimecmp             <= '1;
      tmr_irq              <= 1'b0;
    end else begin
      if (reg_wr && reg_addr == A_GPIOA_OUT) io_pads_gpioA_o_oval <= reg_wdata;
      if (reg_wr && reg_addr == A_GPIOA_OE)  io_pads_gpioA_o_oe   <= reg_wdata;
      if (reg_wr && reg_addr == A_GPIOB_OUT) io_pads_gpioB_o_oval <= reg_wdata;
      if (reg_wr && reg_addr == A_GPIOB_OE)  io_pads_gpioB_o_oe   <= reg_wdata;
      if (reg_wr && reg_addr == A_MTIMECMP)  mtimecmp             <= reg_wdata;
      // A bus write beats a coincident tick
      if (reg_wr && reg_addr == A_MTIME) mtime <= reg_wdata;
      else if (lf_tick)                  mtime <= mtime + DW'(1);
      tmr_irq <= (mtime >= mtimecmp);
    end
  end

  // Read mux; samples pre-write values so a same-cycle read/write returns old data
  logic [DW-1:0] rd_mux_c;
  always_comb begin
    rd_mux_c = '0;
    case (reg_addr)
      A_GPIOA_OUT: rd_mux_c = io_pads_gpioA_o_oval;
      A_GPIOA_OE:  rd_mux_c = io_pads_gpioA_o_oe;
      A_GPIOA_IN:  rd_mux_c = gpioa_s2;
      A_GPIOB_OUT: rd_mux_c = io_pads_gpioB_o_oval;
      A_GPIOB_OE:  rd_mux_c = io_pads_gpioB_o_oe;
      A_GPIOB_IN:  rd_mux_c = gpiob_s2;
      A_STATUS:    rd_mux_c = DW'(strap_q);
      A_RESET_VEC: rd_mux_c = strap_q[0] ? VEC_FLASH : VEC_ROM;
      A_MTIME:     rd_mux_c = mtime;
      A_MTIMECMP:  rd_mux_c = mtimecmp;
      A_IRQ:       rd_mux_c = DW'(tmr_irq);
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge hfextclk) begin
    if (irst)        reg_rdata <= '0;
    else if (reg_rd) reg_rdata <= rd_mux_c;
  end

endmodule

// File: tb/tb_e203_soc_pad_ctrl.sv
// Self-checking bench for e203_soc_pad_ctrl: randomized register traffic
// against a transaction-level register/timer model, plus directed reset,
// strap, timer and external-reset scenarios.
module tb_e203_soc_pad_ctrl;

  logic hfextclk = 1'b0;
  always #5 hfextclk = ~hfextclk;

  logic        rst, lfextclk, hfxoscen, lfxoscen;
  logic        tck, tms, tdi, tdo, tdo_oe;
  logic [31:0] ga_i, ga_o, ga_oe, gb_i, gb_o, gb_oe;
  logic        sck, cs0;
  logic [3:0]  dq_i, dq_o, dq_oe;
  logic        erst_n, dwake_n, vddpaden, padrst, boot_n;
  logic [2:0]  dbg_n;
  logic        reg_wr, reg_rd;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        sys_rst, tmr_irq;

  e203_soc_pad_ctrl dut (
    .hfextclk(hfextclk), .rst(rst), .lfextclk(lfextclk),
    .hfxoscen(hfxoscen), .lfxoscen(lfxoscen),
    .io_pads_jtag_TCK_i_ival(tck), .io_pads_jtag_TMS_i_ival(tms),
    .io_pads_jtag_TDI_i_ival(tdi),
    .io_pads_jtag_TDO_o_oval(tdo), .io_pads_jtag_TDO_o_oe(tdo_oe),
    .io_pads_gpioA_i_ival(ga_i), .io_pads_gpioA_o_oval(ga_o), .io_pads_gpioA_o_oe(ga_oe),
    .io_pads_gpioB_i_ival(gb_i), .io_pads_gpioB_o_oval(gb_o), .io_pads_gpioB_o_oe(gb_oe),
    .io_pads_qspi0_sck_o_oval(sck), .io_pads_qspi0_cs_0_o_oval(cs0),
    .io_pads_qspi0_dq_0_i_ival(dq_i[0]), .io_pads_qspi0_dq_0_o_oval(dq_o[0]), .io_pads_qspi0_dq_0_o_oe(dq_oe[0]),
    .io_pads_qspi0_dq_1_i_ival(dq_i[1]), .io_pads_qspi0_dq_1_o_oval(dq_o[1]), .io_pads_qspi0_dq_1_o_oe(dq_oe[1]),
    .io_pads_qspi0_dq_2_i_ival(dq_i[2]), .io_pads_qspi0_dq_2_o_oval(dq_o[2]), .io_pads_qspi0_dq_2_o_oe(dq_oe[2]),
    .io_pads_qspi0_dq_3_i_ival(dq_i[3]), .io_pads_qspi0_dq_3_o_oval(dq_o[3]), .io_pads_qspi0_dq_3_o_oe(dq_oe[3]),
    .io_pads_aon_erst_n_i_ival(erst_n),
    .io_pads_aon_pmu_dwakeup_n_i_ival(dwake_n),
    .io_pads_aon_pmu_vddpaden_o_oval(vddpaden),
    .io_pads_aon_pmu_padrst_o_oval(padrst),
    .io_pads_bootrom_n_i_ival(boot_n),
    .io_pads_dbgmode0_n_i_ival(dbg_n[0]), .io_pads_dbgmode1_n_i_ival(dbg_n[1]),
    .io_pads_dbgmode2_n_i_ival(dbg_n[2]),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .sys_rst(sys_rst), .tmr_irq(tmr_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register contents by word index
  logic [31:0] m_reg [0:15];
  logic [4:0]  m_straps;

  function automatic bit is_rw(input logic [5:0] a);
    return (a[1:0] == 2'b00) &&
           (a[5:2] inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd8, 4'd9});
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    case (a[5:2])
      4'd0, 4'd1, 4'd3, 4'd4, 4'd8, 4'd9: return m_reg[a[5:2]];
      4'd2:  return ga_i;
      4'd5:  return gb_i;
      4'd6:  return {27'h0, m_straps};
      4'd7:  return m_straps[0] ? 32'h2000_0000 : 32'h0000_1000;
      4'd10: return {31'h0, m_reg[8] >= m_reg[9]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    m_reg[9]  = 32'hFFFF_FFFF;
    m_straps  = {dwake_n, dbg_n, boot_n};
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge hfextclk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_wr = 1'b0;
    if (is_rw(a)) m_reg[a[5:2]] = d;
    step();
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    step();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] a);
    logic [31:0] d;
    bus_rd(a, d);
    check_eq(tag, d, m_read(a));
  endtask

  task automatic lf_period();
    lfextclk = 1'b1; step(4);
    lfextclk = 1'b0; step(4);
    m_reg[8] = m_reg[8] + 32'd1;
  endtask

  task automatic do_reset(input logic b, input logic [2:0] dm, input logic w);
    boot_n = b; dbg_n = dm; dwake_n = w;
    rst = 1'b1;
    step(5);
    rst = 1'b0;
    m_clear();
    step(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; lfextclk = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    ga_i = '0; gb_i = '0; dq_i = '0; erst_n = 1'b1;
    dwake_n = 1'b1; boot_n = 1'b0; dbg_n = 3'b111;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    step(5);

    // Pads idle during reset
    check_eq("rst_cs0", 32'(cs0), 32'h1);
    check_eq("rst_sck", 32'(sck), 32'h0);
    check_eq("rst_gpio_oe", ga_oe | gb_oe, 32'h0);
    check_eq("rst_qspi_dq", {24'h0, dq_oe, dq_o}, 32'h0);
    check_eq("rst_jtag", {30'h0, tdo, tdo_oe}, 32'h0);
    check_eq("rst_osc", {30'h0, hfxoscen, lfxoscen}, 32'h3);
    check_eq("rst_vddpaden", 32'(vddpaden), 32'h0);
    check_eq("rst_padrst", 32'(padrst), 32'h1);
    check_eq("rst_sys_rst", 32'(sys_rst), 32'h1);
    check_eq("rst_irq", 32'(tmr_irq), 32'h0);
    check_eq("rst_rdata", reg_rdata, 32'h0);

    // Reset release: internal reset lingers while erst_n crosses its synchronizer
    rst = 1'b0;
    m_clear();
    step(2);
    check_eq("rel_sys_rst_hold", 32'(sys_rst), 32'h1);
    step(1);
    check_eq("rel_sys_rst_drop", 32'(sys_rst), 32'h0);
    check_eq("rel_vddpaden", 32'(vddpaden), 32'h1);

    rd_check("mtimecmp_rst", 6'h24);
    rd_check("status_boot0", 6'h18);
    check_eq("status_val", m_read(6'h18), 32'h1E);
    rd_check("resetvec_boot0", 6'h1C);

    // GPIO A outputs
    bus_wr(6'h00, 32'hA5A5_0F0F);
    bus_wr(6'h04, 32'hFFFF_0000);
    check_eq("gpioa_oval", ga_o, 32'hA5A5_0F0F);
    check_eq("gpioa_oe", ga_oe, 32'hFFFF_0000);

    // GPIO B input two cycles after pad change
    gb_i = 32'h1234_5678;
    step(2);
    rd_check("gpiob_in", 6'h14);

    // Same-cycle read and write return the old value
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 6'h0C; reg_wdata = 32'hDEAD_BEEF;
    step();
    reg_rd = 1'b0; reg_wr = 1'b0;
    check_eq("rdwr_old", reg_rdata, m_reg[3]);
    m_reg[3] = 32'hDEAD_BEEF;
    step();
    check_eq("rdwr_pad", gb_o, 32'hDEAD_BEEF);
    rd_check("rdwr_new", 6'h0C);

    // Randomized register traffic
    for (int it = 0; it < 60; it++) begin
      logic [5:0] a;
      ga_i = $urandom;
      gb_i = $urandom;
      a = 6'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 6'($urandom_range(1, 3));
      bus_wr(a, $urandom);
      step(2);
      a = 6'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a | 6'($urandom_range(1, 3));
      rd_check("rand_rd", a);
      check_eq("rand_pads", ga_o ^ ga_oe ^ gb_o ^ gb_oe,
               m_reg[0] ^ m_reg[1] ^ m_reg[3] ^ m_reg[4]);
      check_eq("rand_irq", 32'(tmr_irq), 32'(m_reg[8] >= m_reg[9]));
    end

    // Timer compare: 5 lf periods from 0
    bus_wr(6'h20, 32'h0);
    bus_wr(6'h24, 32'd5);
    for (int p = 0; p < 4; p++) lf_period();
    check_eq("irq_before_cmp", 32'(tmr_irq), 32'h0);
    lf_period();
    check_eq("irq_at_cmp", 32'(tmr_irq), 32'h1);
    rd_check("mtime_5", 6'h20);
    rd_check("irq_reg", 6'h28);
    bus_wr(6'h24, 32'hFFFF_FFFF);
    check_eq("irq_cleared", 32'(tmr_irq), 32'h0);

    // Tick latency: MTIME moves on the 3rd edge, IRQ on the 4th
    bus_wr(6'h20, 32'd10);
    bus_wr(6'h24, 32'd11);
    lfextclk = 1'b1;
    step(3);
    check_eq("lat_irq_3", 32'(tmr_irq), 32'h0);
    step(1);
    check_eq("lat_irq_4", 32'(tmr_irq), 32'h1);
    m_reg[8] = 32'd11;
    lfextclk = 1'b0; step(4);
    rd_check("lat_mtime", 6'h20);

    // Wrap
    bus_wr(6'h20, 32'hFFFF_FFFF);
    lf_period();
    rd_check("mtime_wrap", 6'h20);
    check_eq("mtime_wrap_val", m_reg[8], 32'h0);

    // Write collides with tick: write wins
    lfextclk = 1'b1; step(2);
    bus_wr(6'h20, 32'd100);
    lfextclk = 1'b0; step(4);
    rd_check("mtime_wr_wins", 6'h20);

    // External reset pulse mid-run
    bus_wr(6'h00, 32'h5555_AAAA);
    bus_wr(6'h10, 32'h0F0F_0F0F);
    erst_n = 1'b0;
    step(2);
    check_eq("erst_sys_rst_2", 32'(sys_rst), 32'h0);
    step(1);
    check_eq("erst_sys_rst_3", 32'(sys_rst), 32'h1);
    check_eq("erst_padrst", 32'(padrst), 32'h1);
    check_eq("erst_vddpaden", 32'(vddpaden), 32'h0);
    check_eq("erst_gpio_clr", ga_o | gb_oe, 32'h0);
    boot_n = 1'b1; dwake_n = 1'b0; dbg_n = 3'b010;
    step(4);
    erst_n = 1'b1;
    m_clear();
    step(2);
    check_eq("erst_rel_2", 32'(sys_rst), 32'h1);
    step(1);
    check_eq("erst_rel_3", 32'(sys_rst), 32'h0);
    rd_check("erst_gpioa_out", 6'h00);
    rd_check("erst_mtimecmp", 6'h24);
    rd_check("erst_status", 6'h18);

    // Straps hold after reset even if pins change
    boot_n = 1'b0; dwake_n = 1'b1;
    step(4);
    rd_check("strap_hold_status", 6'h18);
    rd_check("strap_hold_vec", 6'h1C);

    // Full reset with bootrom_n = 1
    do_reset(1'b1, 3'b111, 1'b1);
    rd_check("resetvec_boot1", 6'h1C);
    check_eq("resetvec_boot1_val", m_read(6'h1C), 32'h2000_0000);
    rd_check("status_boot1", 6'h18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
